instruction_fetch: RTL and testbench

Instruction fetch unit for the single-issue RISC-V core. It sits at the sending end of the `Instruction` path into the main `Control` decoder. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It holds each fetched word for the decode/execute stage under a valid/ready handshake and redirects the PC on taken branches and jumps (Jal/Jalr/Sb).

---
 rtl/instruction_fetch.sv | 176 +++++++++++++++++
 tb/tb_instruction_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction words over a req/ack port and
// holds each one for decode under valid/ready. FETCH_PERF_EN adds FetchCount/FlushCount.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [6:0]  Opcode,
    output logic [31:0] InstrPC,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 7;
    localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        VALID = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_addr_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] instr_pc_q;
    logic [XLEN-1:0] instr_pc_d;
    logic [XLEN-1:0] target;
    logic            consume;
    logic            flush;
    logic            unused_target_lsbs;

    // Redirect targets are word aligned; the low bits carry no information.
    assign target             = {RedirectPC[XLEN-1:2], 2'b00};
    assign unused_target_lsbs = ^RedirectPC[1:0];

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath update decisions
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        req_addr_d = req_addr;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        consume    = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                state_d    = FETCH;
                req_addr_d = pc;
            end
            FETCH: begin
                if (Redirect) begin
                    flush = 1'b1;
                    pc_d  = target;
                    if (MemAck) begin
                        req_addr_d = target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (MemAck) begin
                    instr_d    = MemRData;
                    instr_pc_d = req_addr;
                    pc_d       = req_addr + WORD_BYTES;
                    state_d    = VALID;
                end
            end
            DRAIN: begin
                // The outstanding request must complete; its data is thrown away.
                if (Redirect) begin
                    flush = 1'b1;
                    pc_d  = target;
                end
                if (MemAck) begin
                    req_addr_d = Redirect ? target : pc;
                    state_d    = FETCH;
                end
            end
            VALID: begin
                if (Redirect) begin
                    flush      = 1'b1;
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = FETCH;
                end else if (InstrReady) begin
                    consume    = 1'b1;
                    req_addr_d = pc;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        MemReq     = 1'b0;
        InstrValid = 1'b0;
        case (state)
            FETCH, DRAIN: MemReq     = 1'b1;
            VALID:        InstrValid = 1'b1;
            default:      ;
        endcase
    end

    // PC, request address and held instruction
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
        end else begin
            pc         <= pc_d;
            req_addr   <= req_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign MemAddr     = req_addr;
    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign Opcode      = instr_q[OPW-1:0];

`ifdef FETCH_PERF_EN
    // Consumed-instruction and flush counters, free-running modulo 2^32
    always_ff @(posedge Clock) begin
        if (Reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (consume) begin
                FetchCount <= FetchCount + XLEN'(1);
            end
            if (flush) begin
                FlushCount <= FlushCount + XLEN'(1);
            end
        end
    end
`else
    logic unused_perf_events;
    assign unused_perf_events = consume ^ flush;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: random memory latency, ready and redirects,
// scored against an address-stream model of what the consumer should receive.
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        Clock      = 1'b0;
    logic        Reset      = 1'b1;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck     = 1'b0;
    logic [31:0] MemRData   = '0;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [31:0] Instruction;
    logic [6:0]  Opcode;
    logic [31:0] InstrPC;
    logic        Redirect   = 1'b0;
    logic [31:0] RedirectPC = '0;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .MemAck      (MemAck),
        .MemRData    (MemRData),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instruction (Instruction),
        .Opcode      (Opcode),
        .InstrPC     (InstrPC),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount  (FetchCount),
        .FlushCount  (FlushCount)
`endif
    );

    always #5 Clock = ~Clock;

    int          checks   = 0;
    int          errors   = 0;
    int          consumed = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_pc = RESET_PC;
    int unsigned model_fetch = 0;
    int unsigned model_flush = 0;
    int unsigned mem_min_wait = 0;
    int unsigned mem_max_wait = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] h;
        h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
        return h ^ (h >> 15);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic model_reset();
        model_pc    = RESET_PC;
        model_fetch = 0;
        model_flush = 0;
    endtask

    // Drive one cycle of consumer/branch stimulus and predict what gets consumed.
    task automatic drive(input logic rdy, input logic rd, input logic [31:0] tgt);
        logic rd_eff;
        rd_eff     = rd && (MemReq || InstrValid);
        InstrReady = rdy;
        Redirect   = rd_eff;
        RedirectPC = tgt;
        if (rd_eff) begin
            model_pc = {tgt[31:2], 2'b00};
            model_flush++;
        end else if (rdy && InstrValid) begin
            exp_q.push_back({model_pc, memword(model_pc)});
            model_pc = model_pc + 32'd4;
            model_fetch++;
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            tick();
            drive(1'b0, 1'b0, '0);
            n++;
        end while (!InstrValid && n < 20);
        if (!InstrValid) chk(name, 32'(InstrValid), 32'd1);
    endtask

    // Instruction memory: acks after a random number of wait cycles.
    int wait_cnt = -1;
    always @(negedge Clock) begin
        if (MemAck) begin
            MemAck   = 1'b0;
            wait_cnt = -1;
        end else if (MemReq && !Reset) begin
            if (wait_cnt < 0) wait_cnt = int'($urandom_range(mem_max_wait, mem_min_wait));
            if (wait_cnt == 0) begin
                MemAck   = 1'b1;
                MemRData = memword(MemAddr);
                wait_cnt = -1;
            end else begin
                wait_cnt--;
            end
        end else begin
            wait_cnt = -1;
        end
    end

    // Monitor: scores every consumed instruction and the memory request protocol.
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic        prev_rst  = 1'b1;
    logic [31:0] prev_addr = '0;
    always @(negedge Clock) begin
        logic [63:0] item;
        #2;
        if (!Reset && InstrValid && InstrReady && !Redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_consume", 32'd1, 32'd0);
            end else begin
                item = exp_q.pop_front();
                consumed++;
                chk("instr_pc", InstrPC, item[63:32]);
                chk("instruction", Instruction, item[31:0]);
                chk("opcode", 32'(Opcode), 32'(item[6:0]));
            end
        end
        if (prev_req && !prev_ack && !prev_rst) begin
            chk("req_hold", 32'(MemReq), 32'd1);
            chk("addr_hold", MemAddr, prev_addr);
        end
        if (MemReq) chk("addr_align", 32'(MemAddr[1:0]), 32'd0);
        prev_req  = MemReq;
        prev_ack  = MemAck;
        prev_rst  = Reset;
        prev_addr = MemAddr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [31:0] old_addr;
        logic        got_ack;
        logic [31:0] tgt;

        repeat (3) tick();
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memaddr", MemAddr, RESET_PC);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instruction", Instruction, NOP);
        chk("rst_opcode", 32'(Opcode), 32'h13);
        chk("rst_instrpc", InstrPC, RESET_PC);
`ifdef FETCH_PERF_EN
        chk("rst_fetchcount", FetchCount, 32'd0);
        chk("rst_flushcount", FlushCount, 32'd0);
`endif
        Reset = 1'b0;
        model_reset();

        // Leaving reset: one IDLE cycle, then the first request to RESET_PC.
        tick();
        drive(1'b1, 1'b0, '0);
        chk("first_req", 32'(MemReq), 32'd1);
        chk("first_addr", MemAddr, RESET_PC);
        for (int i = 0; i < 12; i++) begin
            tick();
            drive(1'b1, 1'b0, '0);
        end

        // Stall in VALID: instruction held, no new request.
        wait_valid("stall_wait");
        held = Instruction;
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(1'b0, 1'b0, '0);
            chk("stall_valid", 32'(InstrValid), 32'd1);
            chk("stall_instr", Instruction, held);
            chk("stall_noreq", 32'(MemReq), 32'd0);
        end
        tick();
        drive(1'b1, 1'b0, '0);
        chk("ready_cycle_noreq", 32'(MemReq), 32'd0);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("req_after_ready", 32'(MemReq), 32'd1);

        // Redirect in VALID beats InstrReady; target low bits are dropped.
        wait_valid("redir_valid_wait");
        drive(1'b1, 1'b1, 32'h0000_0103);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("redir_valid_req", 32'(MemReq), 32'd1);
        chk("redir_valid_addr", MemAddr, 32'h0000_0100);
        chk("redir_valid_novalid", 32'(InstrValid), 32'd0);

        // Redirect in FETCH with a slow memory: old request drains first.
        wait_valid("redir_fetch_wait");
        mem_min_wait = 3;
        mem_max_wait = 3;
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("slow_req", 32'(MemReq), 32'd1);
        chk("slow_noack", 32'(MemAck), 32'd0);
        old_addr = MemAddr;
        drive(1'b0, 1'b1, 32'h0000_0200);
        got_ack = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            drive(1'b0, 1'b0, '0);
            chk("drain_addr", MemAddr, old_addr);
            chk("drain_novalid", 32'(InstrValid), 32'd0);
            if (MemAck) begin
                got_ack = 1'b1;
                break;
            end
        end
        chk("drain_ack_seen", 32'(got_ack), 32'd1);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("redir_fetch_addr", MemAddr, 32'h0000_0200);
        chk("redir_fetch_novalid", 32'(InstrValid), 32'd0);
        mem_min_wait = 0;
        mem_max_wait = 0;

        // PC wrap at the top of the address space.
        wait_valid("wrap_wait1");
        drive(1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid("wrap_wait2");
        drive(1'b1, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("wrap_req", 32'(MemReq), 32'd1);
        chk("wrap_addr", MemAddr, 32'h0000_0000);

        // Reset while a request is outstanding.
        Reset      = 1'b1;
        InstrReady = 1'b0;
        Redirect   = 1'b0;
        model_reset();
        tick();
        chk("midrst_memreq", 32'(MemReq), 32'd0);
        chk("midrst_valid", 32'(InstrValid), 32'd0);
        chk("midrst_instr", Instruction, NOP);
        chk("midrst_instrpc", InstrPC, RESET_PC);
`ifdef FETCH_PERF_EN
        chk("midrst_fetchcount", FetchCount, 32'd0);
        chk("midrst_flushcount", FlushCount, 32'd0);
`endif
        Reset = 1'b0;

        // Randomized traffic.
        mem_min_wait = 0;
        mem_max_wait = 3;
        for (int i = 0; i < 1500; i++) begin
            tick();
            if ($urandom_range(99) == 0) begin
                Reset      = 1'b1;
                InstrReady = 1'b0;
                Redirect   = 1'b0;
                model_reset();
            end else begin
                Reset = 1'b0;
                if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                else                        tgt = $urandom;
                drive(1'($urandom_range(9) < 7), 1'($urandom_range(9) == 0), tgt);
            end
        end

        tick();
        Reset = 1'b0;
        drive(1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("enough_traffic", 32'(consumed > 100), 32'd1);
`ifdef FETCH_PERF_EN
        chk("fetchcount", FetchCount, 32'(model_fetch));
        chk("flushcount", FlushCount, 32'(model_flush));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
